i2c_frame_tx: RTL and testbench

- Parametrised successor to the current fixed-format ball-data I2C link: one block replaces the split controller/master pair.
- Transmits a variable-length frame of up to MAX_BYTES payload bytes to a configurable 7-bit slave address.
- Adds per-byte ACK checking, automatic whole-frame retry on NACK and completion/error reporting.
- Sits between game logic (ball state packer) and the inter-board I2C pins.

---
 rtl/i2c_frame_tx.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_i2c_frame_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_frame_tx.sv
// i2c_frame_tx: I2C master that writes one frame of up to MAX_BYTES payload
// bytes to a fixed 7-bit slave address. Every byte is ACK-checked; a NACK
// ends the attempt with a STOP, and the whole frame is retried up to
// RETRY_MAX more times before nack_err is reported.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous reset, active low
//   send_trigger  single-cycle frame request (ignored while is_transfer=1)
//   payload       byte k = payload[8k+7:8k], byte 0 sent first, MSB first
//   byte_count    number of payload bytes (clamped to MAX_BYTES)
//   SCL           I2C clock, push-pull, idle high
//   SDA           I2C data, open drain (drives 0 or Z)
//   is_transfer   high from trigger acceptance until done/nack_err
//   done          one-cycle pulse, frame fully ACKed and STOP issued
//   nack_err      one-cycle pulse, every attempt NACKed
//   attempt       attempt index of the current/last frame
//   led           debug: [15:8] last byte sent, [7:4] state, [3:0] byte index
module i2c_frame_tx #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned SCL_HZ     = 100_000,
    parameter int unsigned MAX_BYTES  = 8,
    parameter logic [6:0]  SLAVE_ADDR = 7'h42,
    parameter int unsigned RETRY_MAX  = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               send_trigger,
    input  logic [MAX_BYTES*8-1:0]             payload,
    input  logic [$clog2(MAX_BYTES+1)-1:0]     byte_count,
    output logic                               SCL,
    inout  wire                                SDA,
    output logic                               is_transfer,
    output logic                               done,
    output logic                               nack_err,
    output logic [1:0]                         attempt,
    output logic [15:0]                        led
);

    localparam int unsigned QTR = CLK_HZ / (4 * SCL_HZ);
    localparam int unsigned QW  = (QTR > 1) ? $clog2(QTR) : 1;
    localparam int unsigned CW  = $clog2(MAX_BYTES + 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_START   = 4'd1,
        S_ADDR    = 4'd2,
        S_DATA    = 4'd3,
        S_ACK     = 4'd4,
        S_STOP    = 4'd5,
        S_BUSFREE = 4'd6,
        S_RETRY   = 4'd7
    } state_t;

    state_t                 state_q, state_d;
    logic [QW-1:0]          qcnt_q, qcnt_d;
    logic [1:0]             quarter_q, quarter_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             byte_q, byte_d;
    logic [CW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          count_q, count_d;
    logic [MAX_BYTES*8-1:0] payload_q, payload_d;
    logic                   nack_q, nack_d;
    logic                   ack_q, ack_d;
    logic                   addr_ph_q, addr_ph_d;
    logic [1:0]             attempt_q, attempt_d;
    logic [7:0]             last_byte_q, last_byte_d;
    logic                   is_transfer_q, is_transfer_d;
    logic                   done_q, done_d;
    logic                   nack_err_q, nack_err_d;
    logic                   scl_q, scl_d;
    logic                   sda_low_q, sda_low_d;
    logic [15:0]            led_q, led_d;

    logic                   tick;
    logic                   more;
    logic [CW-1:0]          nxt_idx;

    function automatic logic [7:0] pick_byte(input logic [MAX_BYTES*8-1:0] pl,
                                             input logic [CW-1:0] sel);
        logic [7:0] b;
        b = '0;
        for (int unsigned k = 0; k < MAX_BYTES; k++) begin
            if (sel == CW'(k)) b = pl[8*k +: 8];
        end
        return b;
    endfunction

    always_comb begin : next_state
        state_d       = state_q;
        qcnt_d        = qcnt_q;
        quarter_d     = quarter_q;
        bit_d         = bit_q;
        byte_d        = byte_q;
        idx_d         = idx_q;
        count_d       = count_q;
        payload_d     = payload_q;
        nack_d        = nack_q;
        ack_d         = ack_q;
        addr_ph_d     = addr_ph_q;
        attempt_d     = attempt_q;
        last_byte_d   = last_byte_q;
        is_transfer_d = is_transfer_q;
        done_d        = 1'b0;
        nack_err_d    = 1'b0;

        tick    = (state_q != S_IDLE) && (state_q != S_RETRY) && (qcnt_q == QW'(QTR - 1));
        nxt_idx = addr_ph_q ? '0 : CW'(idx_q + 1'b1);
        more    = addr_ph_q ? (count_q != '0) : (CW'(idx_q + 1'b1) < count_q);

        if (state_q == S_IDLE || state_q == S_RETRY || tick) begin
            qcnt_d = '0;
        end else begin
            qcnt_d = qcnt_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (send_trigger) begin
                    payload_d     = payload;
                    count_d       = (byte_count > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : byte_count;
                    attempt_d     = '0;
                    idx_d         = '0;
                    nack_d        = 1'b0;
                    quarter_d     = '0;
                    is_transfer_d = 1'b1;
                    state_d       = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (quarter_q == 2'd1) begin
                        quarter_d = '0;
                        bit_d     = 3'd7;
                        byte_d    = {SLAVE_ADDR, 1'b0};
                        addr_ph_d = 1'b1;
                        state_d   = S_ADDR;
                    end else begin
                        quarter_d = quarter_q + 2'd1;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                if (tick) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q == 2'd3) begin
                        if (bit_q == 3'd0) begin
                            last_byte_d = byte_q;
                            state_d     = S_ACK;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                end
            end
            S_ACK: begin
                if (tick) begin
                    quarter_d = quarter_q + 2'd1;
                    // Slave response is sampled at the end of the first SCL-high quarter.
                    if (quarter_q == 2'd1) ack_d = SDA;
                    if (quarter_q == 2'd3) begin
                        if (ack_q) begin
                            nack_d  = 1'b1;
                            state_d = S_STOP;
                        end else if (more) begin
                            idx_d     = nxt_idx;
                            addr_ph_d = 1'b0;
                            bit_d     = 3'd7;
                            byte_d    = pick_byte(payload_q, nxt_idx);
                            state_d   = S_DATA;
                        end else begin
                            state_d = S_STOP;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (quarter_q == 2'd1) begin
                        quarter_d = '0;
                        state_d   = S_BUSFREE;
                    end else begin
                        quarter_d = quarter_q + 2'd1;
                    end
                end
            end
            S_BUSFREE: begin
                if (tick) begin
                    quarter_d = quarter_q + 2'd1;
                    if (quarter_q == 2'd3) begin
                        if (!nack_q) begin
                            done_d        = 1'b1;
                            is_transfer_d = 1'b0;
                            state_d       = S_IDLE;
                        end else if (attempt_q < 2'(RETRY_MAX)) begin
                            attempt_d = attempt_q + 2'd1;
                            state_d   = S_RETRY;
                        end else begin
                            nack_err_d    = 1'b1;
                            is_transfer_d = 1'b0;
                            state_d       = S_IDLE;
                        end
                    end
                end
            end
            S_RETRY: begin
                // Single clock with the bus idle: rewind to byte 0 and restart
                // from the already-latched payload.
                idx_d     = '0;
                nack_d    = 1'b0;
                quarter_d = '0;
                state_d   = S_START;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus pins and debug word are derived from the next state so that the
    // registered outputs line up with the quarter they belong to.
    always_comb begin : bus_drive
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        unique case (state_d)
            S_START: begin
                scl_d     = 1'b1;
                sda_low_d = (quarter_d == 2'd1);
            end
            S_ADDR, S_DATA: begin
                scl_d     = (quarter_d == 2'd1) || (quarter_d == 2'd2);
                sda_low_d = ~byte_d[bit_d];
            end
            S_ACK: begin
                scl_d     = (quarter_d == 2'd1) || (quarter_d == 2'd2);
                sda_low_d = 1'b0;
            end
            S_STOP: begin
                scl_d     = (quarter_d == 2'd1);
                sda_low_d = 1'b1;
            end
            default: begin
                scl_d     = 1'b1;
                sda_low_d = 1'b0;
            end
        endcase
        led_d = {last_byte_d, state_d, 4'(idx_d)};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            qcnt_q        <= '0;
            quarter_q     <= '0;
            bit_q         <= '0;
            byte_q        <= '0;
            idx_q         <= '0;
            count_q       <= '0;
            payload_q     <= '0;
            nack_q        <= 1'b0;
            ack_q         <= 1'b0;
            addr_ph_q     <= 1'b0;
            attempt_q     <= '0;
            last_byte_q   <= '0;
            is_transfer_q <= 1'b0;
            done_q        <= 1'b0;
            nack_err_q    <= 1'b0;
            scl_q         <= 1'b1;
            sda_low_q     <= 1'b0;
            led_q         <= '0;
        end else begin
            state_q       <= state_d;
            qcnt_q        <= qcnt_d;
            quarter_q     <= quarter_d;
            bit_q         <= bit_d;
            byte_q        <= byte_d;
            idx_q         <= idx_d;
            count_q       <= count_d;
            payload_q     <= payload_d;
            nack_q        <= nack_d;
            ack_q         <= ack_d;
            addr_ph_q     <= addr_ph_d;
            attempt_q     <= attempt_d;
            last_byte_q   <= last_byte_d;
            is_transfer_q <= is_transfer_d;
            done_q        <= done_d;
            nack_err_q    <= nack_err_d;
            scl_q         <= scl_d;
            sda_low_q     <= sda_low_d;
            led_q         <= led_d;
        end
    end

    assign SDA         = sda_low_q ? 1'b0 : 1'bz;
    assign SCL         = scl_q;
    assign is_transfer = is_transfer_q;
    assign done        = done_q;
    assign nack_err    = nack_err_q;
    assign attempt     = attempt_q;
    assign led         = led_q;

endmodule

// File: tb/tb_i2c_frame_tx.sv
// Directed bench for i2c_frame_tx with QTR=1 and a bus-level slave model
// that decodes START/STOP and bytes from sampled SCL/SDA and drives ACKs.
module tb_i2c_frame_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        send_trigger = 1'b0;
    logic [63:0] payload = '0;
    logic [3:0]  byte_count = '0;
    logic        SCL;
    wire         SDA;
    logic        is_transfer, done, nack_err;
    logic [1:0]  attempt;
    logic [15:0] led;

    int vectors = 0;
    int miscompares = 0;

    logic slave_pull = 1'b0;
    assign SDA = slave_pull ? 1'b0 : 1'bz;
    pullup (SDA);

    always #5 clk = ~clk;

    i2c_frame_tx #(
        .CLK_HZ(400), .SCL_HZ(100), .MAX_BYTES(8), .SLAVE_ADDR(7'h42), .RETRY_MAX(2)
    ) dut (
        .clk(clk), .reset(reset), .send_trigger(send_trigger), .payload(payload),
        .byte_count(byte_count), .SCL(SCL), .SDA(SDA), .is_transfer(is_transfer),
        .done(done), .nack_err(nack_err), .attempt(attempt), .led(led)
    );

    // Slave model state (written only by the monitor below)
    logic       prev_scl = 1'b1, prev_sda = 1'b1, in_frame = 1'b0;
    logic [7:0] shreg = '0;
    logic [7:0] seen [0:63];
    int bitcnt = 0, byte_in_frame = 0, rises = 0, last_rises = 0;
    int starts = 0, stops = 0, seen_n = 0;
    // NACK control (written only by the initial block)
    int nack_sel = -1, nack_until = 0;

    always @(negedge clk) begin
        prev_scl <= SCL;
        prev_sda <= SDA;
        if (!reset) begin
            in_frame   <= 1'b0;
            bitcnt     <= 0;
            slave_pull <= 1'b0;
        end else if (SCL && prev_scl && prev_sda && !SDA) begin
            in_frame      <= 1'b1;
            bitcnt        <= 0;
            byte_in_frame <= 0;
            rises         <= 0;
            starts        <= starts + 1;
            slave_pull    <= 1'b0;
        end else if (SCL && prev_scl && !prev_sda && SDA) begin
            // The final SCL rise before STOP belongs to the STOP condition, not a bit.
            stops      <= stops + 1;
            last_rises <= rises - 1;
            in_frame   <= 1'b0;
            bitcnt     <= 0;
        end else if (in_frame && SCL && !prev_scl) begin
            rises <= rises + 1;
            if (bitcnt < 8) begin
                shreg  <= {shreg[6:0], SDA};
                bitcnt <= bitcnt + 1;
            end else begin
                if (seen_n < 64) seen[seen_n] <= shreg;
                seen_n        <= seen_n + 1;
                byte_in_frame <= byte_in_frame + 1;
                bitcnt        <= 0;
            end
        end else if (in_frame && !SCL && prev_scl) begin
            if (bitcnt == 8)
                slave_pull <= !((byte_in_frame == nack_sel) && (starts <= nack_until));
            else if (bitcnt == 0)
                slave_pull <= 1'b0;
        end
    end

    task automatic fire(input logic [63:0] pl, input logic [3:0] cnt);
        payload = pl; byte_count = cnt; send_trigger = 1'b1;
        @(posedge clk); #1;
        send_trigger = 1'b0;
    endtask

    task automatic wait_frame(input int trig_at, output int dcnt, output int ncnt,
                              output logic tmo, output logic aligned);
        dcnt = 0; ncnt = 0; tmo = 1'b1; aligned = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c == trig_at) begin
                send_trigger = 1'b1; payload = '1; byte_count = 4'd8;
            end else begin
                send_trigger = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin dcnt++; if (is_transfer) aligned = 1'b0; end
            if (nack_err) begin ncnt++; if (is_transfer) aligned = 1'b0; end
            if (!is_transfer) begin tmo = 1'b0; break; end
        end
        send_trigger = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
            if (nack_err) ncnt++;
        end
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++; if (SCL !== 1'b1) begin miscompares++; $display("FAIL reset_scl: got %b want 1", SCL); end
        vectors++; if (SDA !== 1'b1) begin miscompares++; $display("FAIL reset_sda: got %b want 1 (released)", SDA); end
        vectors++; if (is_transfer !== 1'b0) begin miscompares++; $display("FAIL reset_is_transfer: got %b want 0", is_transfer); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (nack_err !== 1'b0) begin miscompares++; $display("FAIL reset_nack_err: got %b want 0", nack_err); end
        vectors++; if (attempt !== 2'd0) begin miscompares++; $display("FAIL reset_attempt: got %0d want 0", attempt); end
        vectors++; if (led !== 16'h0000) begin miscompares++; $display("FAIL reset_led: got %h want 0000", led); end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_normal();
        logic [7:0] exp_b [0:4] = '{8'h84, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
        int base, s0, dc, nc; logic tmo, al;
        base = seen_n; s0 = starts;
        fire(64'h0000_0000_A1B2_C3D4, 4'd4);
        vectors++; if (is_transfer !== 1'b1) begin miscompares++; $display("FAIL normal_is_transfer_rise: got %b want 1", is_transfer); end
        wait_frame(-1, dc, nc, tmo, al);
        vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL normal_timeout: got %b want 0", tmo); end
        vectors++; if (seen_n - base !== 5) begin miscompares++; $display("FAIL normal_bytes: got %0d want 5", seen_n - base); end
        for (int i = 0; i < 5; i++) begin
            vectors++; if (seen[base+i] !== exp_b[i]) begin miscompares++; $display("FAIL normal_byte%0d: got %h want %h", i, seen[base+i], exp_b[i]); end
        end
        vectors++; if (last_rises !== 45) begin miscompares++; $display("FAIL normal_scl_rises: got %0d want 45", last_rises); end
        vectors++; if (dc !== 1) begin miscompares++; $display("FAIL normal_done_pulses: got %0d want 1", dc); end
        vectors++; if (nc !== 0) begin miscompares++; $display("FAIL normal_nack_pulses: got %0d want 0", nc); end
        vectors++; if (al !== 1'b1) begin miscompares++; $display("FAIL normal_end_aligned: got %b want 1", al); end
        vectors++; if (attempt !== 2'd0) begin miscompares++; $display("FAIL normal_attempt: got %0d want 0", attempt); end
        vectors++; if (starts - s0 !== 1) begin miscompares++; $display("FAIL normal_starts: got %0d want 1", starts - s0); end
        vectors++; if (led !== 16'hA103) begin miscompares++; $display("FAIL normal_led: got %h want a103", led); end
    endtask

    task automatic test_probe();
        int base, dc, nc; logic tmo, al;
        base = seen_n;
        fire(64'h0000_0000_0000_00FF, 4'd0);
        wait_frame(-1, dc, nc, tmo, al);
        vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL probe_timeout: got %b want 0", tmo); end
        vectors++; if (seen_n - base !== 1) begin miscompares++; $display("FAIL probe_bytes: got %0d want 1", seen_n - base); end
        vectors++; if (seen[base] !== 8'h84) begin miscompares++; $display("FAIL probe_addr: got %h want 84", seen[base]); end
        vectors++; if (last_rises !== 9) begin miscompares++; $display("FAIL probe_scl_rises: got %0d want 9", last_rises); end
        vectors++; if (dc !== 1) begin miscompares++; $display("FAIL probe_done_pulses: got %0d want 1", dc); end
    endtask

    task automatic test_clamp();
        int base, dc, nc; logic tmo, al;
        base = seen_n;
        fire(64'h0807_0605_0403_0201, 4'd15);
        wait_frame(-1, dc, nc, tmo, al);
        vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL clamp_timeout: got %b want 0", tmo); end
        vectors++; if (seen_n - base !== 9) begin miscompares++; $display("FAIL clamp_bytes: got %0d want 9", seen_n - base); end
        for (int i = 1; i < 9; i++) begin
            vectors++; if (seen[base+i] !== 8'(i)) begin miscompares++; $display("FAIL clamp_byte%0d: got %h want %h", i, seen[base+i], 8'(i)); end
        end
        vectors++; if (last_rises !== 81) begin miscompares++; $display("FAIL clamp_scl_rises: got %0d want 81", last_rises); end
        vectors++; if (dc !== 1) begin miscompares++; $display("FAIL clamp_done_pulses: got %0d want 1", dc); end
    endtask

    task automatic test_nack_retry();
        logic [7:0] exp_b [0:6] = '{8'h84, 8'h11, 8'h22, 8'h84, 8'h11, 8'h22, 8'h33};
        int base, s0, p0, dc, nc; logic tmo, al;
        base = seen_n; s0 = starts; p0 = stops;
        nack_sel = 2; nack_until = starts + 1;
        fire(64'h0000_0000_0033_2211, 4'd3);
        wait_frame(60, dc, nc, tmo, al);
        nack_sel = -1;
        vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL retry_timeout: got %b want 0", tmo); end
        vectors++; if (seen_n - base !== 7) begin miscompares++; $display("FAIL retry_bytes: got %0d want 7", seen_n - base); end
        for (int i = 0; i < 7; i++) begin
            vectors++; if (seen[base+i] !== exp_b[i]) begin miscompares++; $display("FAIL retry_byte%0d: got %h want %h", i, seen[base+i], exp_b[i]); end
        end
        vectors++; if (starts - s0 !== 2) begin miscompares++; $display("FAIL retry_starts: got %0d want 2", starts - s0); end
        vectors++; if (stops - p0 !== 2) begin miscompares++; $display("FAIL retry_stops: got %0d want 2", stops - p0); end
        vectors++; if (dc !== 1) begin miscompares++; $display("FAIL retry_done_pulses: got %0d want 1", dc); end
        vectors++; if (nc !== 0) begin miscompares++; $display("FAIL retry_nack_pulses: got %0d want 0", nc); end
        vectors++; if (attempt !== 2'd1) begin miscompares++; $display("FAIL retry_attempt: got %0d want 1", attempt); end
        vectors++; if (is_transfer !== 1'b0) begin miscompares++; $display("FAIL retry_no_queued_frame: got %b want 0", is_transfer); end
    endtask

    task automatic test_exhausted();
        int base, s0, p0, dc, nc; logic tmo, al;
        base = seen_n; s0 = starts; p0 = stops;
        nack_sel = 0; nack_until = 1000000;
        fire(64'h0000_0000_0000_5566, 4'd2);
        wait_frame(-1, dc, nc, tmo, al);
        nack_sel = -1;
        vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL exhaust_timeout: got %b want 0", tmo); end
        vectors++; if (starts - s0 !== 3) begin miscompares++; $display("FAIL exhaust_starts: got %0d want 3", starts - s0); end
        vectors++; if (stops - p0 !== 3) begin miscompares++; $display("FAIL exhaust_stops: got %0d want 3", stops - p0); end
        vectors++; if (seen_n - base !== 3) begin miscompares++; $display("FAIL exhaust_bytes: got %0d want 3", seen_n - base); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (seen[base+i] !== 8'h84) begin miscompares++; $display("FAIL exhaust_addr%0d: got %h want 84", i, seen[base+i]); end
        end
        vectors++; if (nc !== 1) begin miscompares++; $display("FAIL exhaust_nack_pulses: got %0d want 1", nc); end
        vectors++; if (dc !== 0) begin miscompares++; $display("FAIL exhaust_done_pulses: got %0d want 0", dc); end
        vectors++; if (al !== 1'b1) begin miscompares++; $display("FAIL exhaust_end_aligned: got %b want 1", al); end
        vectors++; if (attempt !== 2'd2) begin miscompares++; $display("FAIL exhaust_attempt: got %0d want 2", attempt); end
    endtask

    task automatic test_reset_mid();
        int base, dc, nc; logic tmo, al, found;
        fire(64'h0000_0000_1122_3344, 4'd4);
        vectors++; if (attempt !== 2'd0) begin miscompares++; $display("FAIL attempt_cleared: got %0d want 0", attempt); end
        found = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (led[7:4] == 4'd3) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL midreset_reach_data: got %b want 1", found); end
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        vectors++; if (SCL !== 1'b1) begin miscompares++; $display("FAIL midreset_scl: got %b want 1", SCL); end
        vectors++; if (SDA !== 1'b1) begin miscompares++; $display("FAIL midreset_sda: got %b want 1 (released)", SDA); end
        vectors++; if (is_transfer !== 1'b0) begin miscompares++; $display("FAIL midreset_is_transfer: got %b want 0", is_transfer); end
        vectors++; if (led !== 16'h0000) begin miscompares++; $display("FAIL midreset_led: got %h want 0000", led); end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        base = seen_n;
        fire(64'h0000_0000_0000_5A3C, 4'd2);
        wait_frame(-1, dc, nc, tmo, al);
        vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL after_reset_timeout: got %b want 0", tmo); end
        vectors++; if (seen_n - base !== 3) begin miscompares++; $display("FAIL after_reset_bytes: got %0d want 3", seen_n - base); end
        vectors++; if (seen[base] !== 8'h84) begin miscompares++; $display("FAIL after_reset_addr: got %h want 84", seen[base]); end
        vectors++; if (seen[base+1] !== 8'h3C) begin miscompares++; $display("FAIL after_reset_b0: got %h want 3c", seen[base+1]); end
        vectors++; if (seen[base+2] !== 8'h5A) begin miscompares++; $display("FAIL after_reset_b1: got %h want 5a", seen[base+2]); end
        vectors++; if (last_rises !== 27) begin miscompares++; $display("FAIL after_reset_scl_rises: got %0d want 27", last_rises); end
        vectors++; if (dc !== 1) begin miscompares++; $display("FAIL after_reset_done_pulses: got %0d want 1", dc); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_probe();
        test_clamp();
        test_nack_retry();
        test_exhausted();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
